// File: rtl/limb_fetch_unit.sv
// rtl/limb_fetch_unit.sv - Limb CPU instruction fetch stage with return-address stack
//
// Owns the program counter, drives the ROM address, latches ROM words into the
// instruction register with a valid/ready handshake towards the decoder, and
// executes jump/call/ret redirects against an internal return-address stack.
//
// Optional feature macro: LIMB_FETCH_FAULT_EN
//   defined   : stack overflow/underflow halts the fetch unit until reset
//   undefined : overflow drops the push, underflow returns to RESET_PC
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   rom_addr          ROM address (always the pc)
//   rom_data          ROM word, combinational from rom_addr
//   ir, ir_pc         instruction register and the address it came from
//   ir_valid/ir_ready decoder handshake
//   redirect*         control transfer, honoured only while ir is consumed
//   stack_depth       return-address stack occupancy
//   halt              fault halt indication

module limb_fetch_unit #(
    parameter int         DEPTH    = 16,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [7:0]                 rom_addr,
    input  logic [31:0]                rom_data,
    output logic [31:0]                ir,
    output logic [7:0]                 ir_pc,
    output logic                       ir_valid,
    input  logic                       ir_ready,
    input  logic                       redirect,
    input  logic [1:0]                 redirect_op,
    input  logic [7:0]                 redirect_target,
    output logic [$clog2(DEPTH):0]     stack_depth,
    output logic                       halt
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    localparam logic [1:0] OP_JUMP = 2'b00;
    localparam logic [1:0] OP_CALL = 2'b01;
    localparam logic [1:0] OP_RET  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]    pc;
    logic [7:0]    pc_next;
    logic [7:0]    stack_mem [DEPTH];

    logic          redir_go;
    logic          is_call;
    logic          is_ret;
    logic          stack_full;
    logic          stack_empty;
    logic          do_push;
    logic          do_pop;
    logic          ir_load;
    logic          ir_clear;
    logic [DW-1:0] depth_m1;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] push_idx;
    logic [7:0]    stack_top;

`ifdef LIMB_FETCH_FAULT_EN
    logic          fault;
`endif

    assign rom_addr = pc;

    // Redirects ride along with consumption of the current ir; op 11 is a no-op
    // and falls through to the ordinary sequential fetch.
    assign redir_go    = (state == S_RUN) && ir_valid && ir_ready && redirect &&
                         (redirect_op != 2'b11);
    assign is_call     = redir_go && (redirect_op == OP_CALL);
    assign is_ret      = redir_go && (redirect_op == OP_RET);
    assign stack_full  = (stack_depth == DW'(DEPTH));
    assign stack_empty = (stack_depth == '0);
    assign do_push     = is_call && !stack_full;
    assign do_pop      = is_ret && !stack_empty;

    assign depth_m1  = stack_depth - DW'(1);
    assign top_idx   = depth_m1[AW-1:0];
    assign push_idx  = stack_depth[AW-1:0];
    assign stack_top = stack_mem[top_idx];

`ifdef LIMB_FETCH_FAULT_EN
    assign fault = (is_call && stack_full) || (is_ret && stack_empty);
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: state_next = S_RUN;
            S_RUN: begin
`ifdef LIMB_FETCH_FAULT_EN
                if (fault) begin
                    state_next = S_HALT;
                end
`endif
            end
            default: state_next = state;
        endcase
    end

    // Output / datapath control logic
    always_comb begin
        pc_next  = pc;
        ir_load  = 1'b0;
        ir_clear = 1'b0;
        case (state)
            S_IDLE: begin
                ir_load = 1'b1;
                pc_next = pc + 8'd1;
            end
            S_RUN: begin
                if (redir_go) begin
                    // The sequential word is dropped; the target loads next cycle.
                    ir_clear = 1'b1;
`ifdef LIMB_FETCH_FAULT_EN
                    if (!fault) begin
                        pc_next = (redirect_op == OP_RET) ? stack_top : redirect_target;
                    end
`else
                    if (redirect_op == OP_RET) begin
                        pc_next = stack_empty ? RESET_PC : stack_top;
                    end else begin
                        pc_next = redirect_target;
                    end
`endif
                end else if (!ir_valid || ir_ready) begin
                    ir_load = 1'b1;
                    pc_next = pc + 8'd1;
                end
            end
            default: begin
                pc_next = pc;
            end
        endcase
    end

`ifdef LIMB_FETCH_FAULT_EN
    assign halt = (state == S_HALT);
`else
    assign halt = 1'b0;
`endif

    // Fetch datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else begin
            pc <= pc_next;
            if (ir_load) begin
                ir       <= rom_data;
                ir_pc    <= pc;
                ir_valid <= 1'b1;
            end else if (ir_clear) begin
                ir_valid <= 1'b0;
            end
        end
    end

    // Return-address stack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stack_depth <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
        end else if (do_push) begin
            stack_mem[push_idx] <= ir_pc + 8'd1;
            stack_depth         <= stack_depth + DW'(1);
        end else if (do_pop) begin
            stack_depth <= depth_m1;
        end
    end

endmodule

// File: tb/tb_limb_fetch_unit.sv
// tb/tb_limb_fetch_unit.sv - directed vector bench for limb_fetch_unit

module tb_limb_fetch_unit;

    localparam int         DEPTH    = 16;
    localparam logic [7:0] RESET_PC = 8'h00;
    localparam int         DW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rom_addr;
    logic [31:0]   rom_data;
    logic [31:0]   ir;
    logic [7:0]    ir_pc;
    logic          ir_valid;
    logic          ir_ready = 1'b0;
    logic          redirect = 1'b0;
    logic [1:0]    redirect_op = 2'b00;
    logic [7:0]    redirect_target = 8'h00;
    logic [DW-1:0] stack_depth;
    logic          halt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          rdy;
        logic          red;
        logic [1:0]    op;
        logic [7:0]    tgt;
        logic          ev;
        logic [7:0]    epc;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    // ROM[n] = n
    assign rom_data = {24'h0, rom_addr};

    limb_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .ir              (ir),
        .ir_pc           (ir_pc),
        .ir_valid        (ir_valid),
        .ir_ready        (ir_ready),
        .redirect        (redirect),
        .redirect_op     (redirect_op),
        .redirect_target (redirect_target),
        .stack_depth     (stack_depth),
        .halt            (halt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rdy, input logic red, input logic [1:0] op,
                       input logic [7:0] tgt, input logic ev, input logic [7:0] epc,
                       input logic [DW-1:0] ed);
        vec_t v;
        v.rdy = rdy; v.red = red; v.op = op; v.tgt = tgt;
        v.ev = ev; v.epc = epc; v.ed = ed;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rdy, input logic red, input logic [1:0] op,
                         input logic [7:0] tgt);
        ir_ready = rdy; redirect = red; redirect_op = op; redirect_target = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ir_valid"}, 32'(ir_valid), 32'd0);
        chk({tag, "_ir"}, ir, 32'd0);
        chk({tag, "_ir_pc"}, 32'(ir_pc), 32'd0);
        chk({tag, "_depth"}, 32'(stack_depth), 32'd0);
        chk({tag, "_halt"}, 32'(halt), 32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'(RESET_PC));
    endtask

    task automatic do_reset(input string tag);
        drive(1'b0, 1'b0, 2'b00, 8'h00);
        reset = 1'b1;
        step();
        step();
        check_reset_values(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One step expecting ir_valid/ir_pc/depth afterwards
    task automatic expect_step(input string name, input logic ev, input logic [7:0] epc,
                               input logic [DW-1:0] ed);
        step();
        chk({name, "_valid"}, 32'(ir_valid), 32'(ev));
        chk({name, "_ir_pc"}, 32'(ir_pc), 32'(epc));
        chk({name, "_depth"}, 32'(stack_depth), 32'(ed));
    endtask

    initial begin
        // ---------------- vector table ----------------
        add(1, 0, 2'b00, 8'h00, 1, 8'h00, 0);
        add(1, 0, 2'b00, 8'h00, 1, 8'h01, 0);
        add(1, 0, 2'b00, 8'h00, 1, 8'h02, 0);
        add(1, 0, 2'b00, 8'h00, 1, 8'h03, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 2'b00, 8'h00, 1, 8'h03, 0);
        for (int i = 4; i <= 10; i++) add(1, 0, 2'b00, 8'h00, 1, 8'(i), 0);
        add(1, 1, 2'b00, 8'h40, 0, 8'h0a, 0);   // jump at ir_pc 10
        add(1, 0, 2'b00, 8'h00, 1, 8'h40, 0);
        add(1, 0, 2'b00, 8'h00, 1, 8'h41, 0);
        add(1, 1, 2'b00, 8'h20, 0, 8'h41, 0);
        add(1, 0, 2'b00, 8'h00, 1, 8'h20, 0);
        add(1, 1, 2'b01, 8'h80, 0, 8'h20, 1);   // call at 0x20
        for (int i = 'h80; i <= 'h85; i++) add(1, 0, 2'b00, 8'h00, 1, 8'(i), 1);
        add(1, 1, 2'b10, 8'h00, 0, 8'h85, 0);   // ret at 0x85
        add(1, 0, 2'b00, 8'h00, 1, 8'h21, 0);
        add(0, 1, 2'b00, 8'h99, 1, 8'h21, 0);   // redirect without ready: ignored
        add(1, 0, 2'b00, 8'h00, 1, 8'h22, 0);
        add(1, 1, 2'b11, 8'h77, 1, 8'h23, 0);   // reserved op: sequential
        add(1, 1, 2'b00, 8'hfe, 0, 8'h23, 0);
        add(1, 0, 2'b00, 8'h00, 1, 8'hfe, 0);
        add(1, 0, 2'b00, 8'h00, 1, 8'hff, 0);
        add(1, 0, 2'b00, 8'h00, 1, 8'h00, 0);   // 8-bit wrap
        add(1, 0, 2'b00, 8'h00, 1, 8'h01, 0);

        do_reset("rst0");
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rdy, tbl[i].red, tbl[i].op, tbl[i].tgt);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(ir_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_ir_pc", i), 32'(ir_pc), 32'(tbl[i].epc));
            chk($sformatf("vec%0d_depth", i), 32'(stack_depth), 32'(tbl[i].ed));
            chk($sformatf("vec%0d_halt", i), 32'(halt), 32'd0);
            if (tbl[i].ev) chk($sformatf("vec%0d_ir", i), ir, {24'h0, tbl[i].epc});
        end

        // ---------------- stack overflow ----------------
        do_reset("rst1");
        drive(1, 0, 2'b00, 8'h00);
        expect_step("ovf_first", 1, 8'h00, 0);
        for (int k = 0; k < DEPTH; k++) begin
            drive(1, 1, 2'b01, 8'(8'h80 + k));
            expect_step($sformatf("ovf_call%0d", k), 0, (k == 0) ? 8'h00 : 8'(8'h80 + k - 1),
                        DW'(k + 1));
            drive(1, 0, 2'b00, 8'h00);
            expect_step($sformatf("ovf_tgt%0d", k), 1, 8'(8'h80 + k), DW'(k + 1));
        end
        drive(1, 1, 2'b01, 8'hc0);
        step();
        chk("ovf_last_valid", 32'(ir_valid), 32'd0);
        chk("ovf_last_depth", 32'(stack_depth), 32'(DEPTH));
`ifdef LIMB_FETCH_FAULT_EN
        chk("ovf_halt", 32'(halt), 32'd1);
        chk("ovf_pc_frozen", 32'(rom_addr), 32'h90);
        drive(1, 0, 2'b00, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("ovf_hold_halt%0d", i), 32'(halt), 32'd1);
            chk($sformatf("ovf_hold_valid%0d", i), 32'(ir_valid), 32'd0);
        end
`else
        chk("ovf_halt", 32'(halt), 32'd0);
        drive(1, 0, 2'b00, 8'h00);
        expect_step("ovf_jump_taken", 1, 8'hc0, DEPTH);
        drive(1, 1, 2'b10, 8'h00);
        expect_step("ovf_ret1", 0, 8'hc0, DEPTH - 1);
        drive(1, 0, 2'b00, 8'h00);
        expect_step("ovf_ret1_tgt", 1, 8'h8f, DEPTH - 1);
        drive(1, 1, 2'b10, 8'h00);
        expect_step("ovf_ret2", 0, 8'h8f, DEPTH - 2);
        drive(1, 0, 2'b00, 8'h00);
        expect_step("ovf_ret2_tgt", 1, 8'h8e, DEPTH - 2);
`endif

        // ---------------- stack underflow ----------------
        do_reset("rst2");
        drive(1, 0, 2'b00, 8'h00);
        expect_step("unf_f0", 1, 8'h00, 0);
        expect_step("unf_f1", 1, 8'h01, 0);
        expect_step("unf_f2", 1, 8'h02, 0);
        drive(1, 1, 2'b10, 8'h55);
        expect_step("unf_ret", 0, 8'h02, 0);
`ifdef LIMB_FETCH_FAULT_EN
        chk("unf_halt", 32'(halt), 32'd1);
`else
        chk("unf_halt", 32'(halt), 32'd0);
        drive(1, 0, 2'b00, 8'h00);
        expect_step("unf_tgt", 1, RESET_PC, 0);
`endif

        // ---------------- reset during a call cycle ----------------
        do_reset("rst3");
        drive(1, 0, 2'b00, 8'h00);
        expect_step("mid_f0", 1, 8'h00, 0);
        drive(1, 1, 2'b01, 8'h50);
        expect_step("mid_call1", 0, 8'h00, 1);
        drive(1, 0, 2'b00, 8'h00);
        expect_step("mid_tgt1", 1, 8'h50, 1);
        drive(1, 1, 2'b01, 8'h60);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("mid_async");
        step();
        check_reset_values("mid_held");
        @(negedge clk);
        reset = 1'b0;
        expect_step("mid_after", 1, 8'h00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
